indexed_mem_array: RTL and testbench
====================================

Name: indexed_mem_array

Overview:
- Parametrised synchronous memory block with one write port and one registered read access.
- Each read access produces three results:
  - a direct-address read word;
  - a read word at an offset address (base + offset, wrapped modulo DEPTH);
  - a single bit selected from the direct-address word.
- Adds write-port forwarding, out-of-range detection and a reset-triggered clear sequencer that zeroes every entry.
- Sits between address-generation logic and datapath consumers that need base/offset table lookups.

Parameters:
- DATA_W, 8, word width in bits (>= 2).
- ADDR_W, 8, address port width in bits.
- DEPTH, 256, number of entries; 2 <= DEPTH <= 2**ADDR_W; need not be a power of two.
- BYPASS, 1, 1 = write-first forwarding on same-cycle address match; 0 = read-first (return the old contents).
- SEL_W, $clog2(DATA_W), width of bit_sel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read strobe.
- rd_addr1  input  ADDR_W  base read address.
- rd_addr2  input  ADDR_W  offset added to rd_addr1.
- bit_sel  input  SEL_W  bit index into the base-address word.
- data_out1  output  DATA_W  mem[rd_addr1], registered.
- data_out2  output  DATA_W  mem[(rd_addr1+rd_addr2) mod DEPTH], registered.
- single_bit  output  1  mem[rd_addr1][bit_sel], registered.
- rd_valid  output  1  one-cycle pulse: read outputs updated.
- busy  output  1  clear sequence in progress.
- err_oob  output  1  one-cycle pulse: out-of-range access.

Behaviour:
- Reset (clk edge with rst=1):
  - data_out1, data_out2, single_bit, rd_valid and err_oob all go to 0.
  - busy goes to 1, state to CLEAR, clr_ptr to 0.
  - Reset asserted mid-clear restarts the clear from clr_ptr=0.
  - Reset asserted mid-read cancels the pending rd_valid.
- FSM, two states:
  - CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr=DEPTH-1 the next state is READY.
  - READY: normal operation.
  - busy=1 exactly while in CLEAR, so busy deasserts DEPTH cycles after the first non-reset edge.
- While busy=1:
  - wr_en and rd_en are ignored: no write, rd_valid=0, err_oob=0.
  - Outputs hold their values.
- Write (READY, wr_en=1):
  - If wr_addr < DEPTH: mem[wr_addr] <= wr_data on the edge.
  - Otherwise: the write is dropped and err_oob pulses.
- Read (READY, rd_en=1):
  - Latency is 1 cycle: inputs sampled on edge N, outputs and rd_valid=1 valid after edge N.
  - rd_valid=0 on cycles without an accepted read; data outputs hold their last values.
- Offset index arithmetic:
  - sum = rd_addr1 + rd_addr2, computed at ADDR_W+1 bits with no truncation.
  - idx2 = sum mod DEPTH (wrap-around).
  - A sum >= DEPTH is legal and is not an error.
- Base index out of range (rd_addr1 >= DEPTH):
  - data_out1=0 and single_bit=0.
  - err_oob pulses with rd_valid.
  - data_out2 is still computed via idx2.
- Bit select:
  - single_bit = data word at rd_addr1, bit bit_sel.
  - bit_sel >= DATA_W gives single_bit=0 and err_oob pulses.
- Same-cycle write and read, same address:
  - BYPASS=1: the matching output(s) return wr_data, and single_bit uses wr_data[bit_sel].
  - BYPASS=0: old contents are returned.
  - This applies independently to the base index and idx2.
- An out-of-range write never forwards.
- Simultaneous err_oob causes (e.g. bad write plus bad read) merge into a single one-cycle pulse.
- Memory contents are defined as 0 after the clear sequence completes. Reads must not be issued before then.

Test Plan:
- Reset released, DEPTH=256: busy stays high for 256 cycles, then drops. A read of rd_addr1=0x10, rd_addr2=0x20 returns data_out1=0, data_out2=0, rd_valid=1 one cycle later.
- Write 0xA5 @0x03 and 0x3C @0x07, then read rd_addr1=0x03, rd_addr2=0x04, bit_sel=2 -> next cycle data_out1=0xA5, data_out2=0x3C, single_bit=1, rd_valid=1, err_oob=0.
- Wrap case, DEPTH=128: write 0x5A @0x04, read rd_addr1=0x7E, rd_addr2=0x06 (sum 0x84) -> data_out2=0x5A, err_oob=0. Then read rd_addr1=0x90 -> data_out1=0, err_oob=1.
- Same-cycle wr_en @0x22 data 0xF0 and rd_addr1=0x22 (old contents 0x11): BYPASS=1 gives data_out1=0xF0; BYPASS=0 gives 0x11, and a re-read gives 0xF0.
- Assert rst for 1 cycle at clr_ptr=100 during a clear, with writes attempted while busy -> the clear restarts; busy lasts a further 256 cycles; the attempted writes leave no trace (all reads return 0).
- Write to wr_addr=0xC8 with DEPTH=200 -> the write is dropped, err_oob pulses once; a subsequent read of address 0xC8 % 200 = 0 is unaffected and returns 0.

Source files
------------

// File: rtl/indexed_mem_array.sv
// indexed_mem_array: single-write-port table with one registered read
// access that returns a base word, a wrapped base+offset word and one
// selected bit of the base word. A clear sequencer zeroes every entry
// after reset; out-of-range writes, reads and bit selects raise err_oob.
module indexed_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BYPASS = 1,
  parameter int SEL_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [SEL_W-1:0]  bit_sel,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              single_bit,
  output logic              rd_valid,
  output logic              busy,
  output logic              err_oob
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V  = DEPTH[ADDR_W:0];
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [SEL_W:0]    DATA_W_V = DATA_W[SEL_W:0];

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   clr_ptr_reg;
  logic               busy_reg;
  logic               rd_valid_reg;
  logic               err_reg;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  word1_reg, word2_reg;

  // Read sideband captured alongside the RAM read data
  logic               zero1_reg, zero2_reg;
  logic               fwd1_reg, fwd2_reg;
  logic               bit_ok_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [SEL_W-1:0]   bsel_reg;

  logic               ready, wr_in_range, rd1_in_range, bit_in_range;
  logic               wr_ok, rd_ok, fwd1, fwd2, mem_we;
  logic [ADDR_W:0]    sum;
  logic [IDX_W-1:0]   idx1, idx2, wr_idx, mem_waddr;
  logic [DATA_W-1:0]  mem_wdata, word1_eff;

  // Address decode, wrap arithmetic and forwarding detection
  always_comb begin
    ready        = (state_reg == ST_READY);
    wr_in_range  = ({1'b0, wr_addr} < DEPTH_V);
    rd1_in_range = ({1'b0, rd_addr1} < DEPTH_V);
    bit_in_range = ({1'b0, bit_sel} < DATA_W_V);
    // Sum kept one bit wider so base+offset never truncates before the wrap
    sum          = {1'b0, rd_addr1} + {1'b0, rd_addr2};
    idx2         = IDX_W'(sum % DEPTH_V);
    idx1         = rd1_in_range ? rd_addr1[IDX_W-1:0] : '0;
    wr_idx       = wr_addr[IDX_W-1:0];
    wr_ok        = ready && wr_en && wr_in_range;
    rd_ok        = ready && rd_en;
    // Forwarding only from a write that actually lands in the array
    fwd1         = (BYPASS != 0) && wr_ok && rd1_in_range && (wr_idx == idx1);
    fwd2         = (BYPASS != 0) && wr_ok && (wr_idx == idx2);
    // The clear sequencer owns the write port while not ready
    mem_we       = !rst && ((state_reg == ST_CLEAR) || wr_ok);
    mem_waddr    = ready ? wr_idx : clr_ptr_reg;
    mem_wdata    = ready ? wr_data : '0;
  end

  // Clear sequencer: walk every entry once after reset, then go ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == LAST_IDX) begin
            state_reg <= ST_READY;
            busy_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array write plus read-first registered reads (no reset on RAM data)
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    if (rd_ok) begin
      word1_reg <= mem[idx1];
      word2_reg <= mem[idx2];
    end
  end

  // Read sideband: forwarding, zero-forcing and bit-select context
  always_ff @(posedge clk) begin
    if (rst) begin
      zero1_reg  <= 1'b1;
      zero2_reg  <= 1'b1;
      fwd1_reg   <= 1'b0;
      fwd2_reg   <= 1'b0;
      bit_ok_reg <= 1'b0;
      wdata_reg  <= '0;
      bsel_reg   <= '0;
    end else if (rd_ok) begin
      zero1_reg  <= !rd1_in_range;
      zero2_reg  <= 1'b0;
      fwd1_reg   <= fwd1;
      fwd2_reg   <= fwd2;
      bit_ok_reg <= bit_in_range;
      wdata_reg  <= wr_data;
      bsel_reg   <= bit_sel;
    end
  end

  // Strobes: one pulse per accepted read; all error causes merge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= rd_ok;
      err_reg      <= ready && ((wr_en && !wr_in_range) ||
                                (rd_en && (!rd1_in_range || !bit_in_range)));
    end
  end

  // Output selection from registered state only
  always_comb begin
    word1_eff  = fwd1_reg ? wdata_reg : word1_reg;
    data_out1  = zero1_reg ? '0 : word1_eff;
    data_out2  = zero2_reg ? '0 : (fwd2_reg ? wdata_reg : word2_reg);
    single_bit = (!zero1_reg && bit_ok_reg) ? word1_eff[bsel_reg] : 1'b0;
  end

  assign rd_valid = rd_valid_reg;
  assign busy     = busy_reg;
  assign err_oob  = err_reg;

endmodule

// File: tb/tb_indexed_mem_array.sv
// Bench for indexed_mem_array: two instances (256x8 write-first and
// 200x6 read-first) share one stimulus stream; a behavioural model
// pushes expected outputs per cycle and they are popped after the edge.
module tb_indexed_mem_array;

  typedef struct packed {
    logic       rv;
    logic       err;
    logic       busy;
    logic       bt;
    logic [7:0] d1;
    logic [7:0] d2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] wr_addr, wr_data, rd_addr1, rd_addr2;
  logic [2:0] bit_sel;

  logic [7:0] a_d1, a_d2;
  logic       a_bit, a_rv, a_busy, a_err;
  logic [5:0] b_d1, b_d2;
  logic       b_bit, b_rv, b_busy, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state, index 0 = instance a, 1 = instance b
  logic [7:0] mm [2][256];
  int         dep  [2] = '{256, 200};
  int         dwid [2] = '{8, 6};
  bit         byp  [2] = '{1'b1, 1'b0};
  bit         bm   [2];
  int         cnt  [2];
  logic [7:0] hd1  [2];
  logic [7:0] hd2  [2];
  logic       hb   [2];

  always #5 clk = ~clk;

  indexed_mem_array u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .bit_sel(bit_sel),
    .data_out1(a_d1), .data_out2(a_d2), .single_bit(a_bit),
    .rd_valid(a_rv), .busy(a_busy), .err_oob(a_err)
  );

  indexed_mem_array #(.DATA_W(6), .ADDR_W(8), .DEPTH(200), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[5:0]),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .bit_sel(bit_sel),
    .data_out1(b_d1), .data_out2(b_d2), .single_bit(b_bit),
    .rd_valid(b_rv), .busy(b_busy), .err_oob(b_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict both instances, compare after the edge
  task automatic step(input bit r, input bit we, input logic [7:0] wa, input logic [7:0] wd,
                      input bit re, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [2:0] bs);
    exp_t       e;
    logic [7:0] msk, w1;
    int         idx2;
    bit         wok;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2; bit_sel = bs;
    for (int i = 0; i < 2; i++) begin
      msk   = 8'((1 << dwid[i]) - 1);
      e.rv  = 1'b0;
      e.err = 1'b0;
      if (r) begin
        hd1[i] = '0; hd2[i] = '0; hb[i] = 1'b0;
        bm[i] = 1'b1; cnt[i] = 0;
        for (int j = 0; j < 256; j++) mm[i][j] = '0;
      end else if (bm[i]) begin
        cnt[i]++;
        if (cnt[i] == dep[i]) bm[i] = 1'b0;
      end else begin
        wok   = we && (int'(wa) < dep[i]);
        e.err = (we && int'(wa) >= dep[i]) ||
                (re && (int'(a1) >= dep[i] || int'(bs) >= dwid[i]));
        if (re) begin
          e.rv = 1'b1;
          idx2 = (int'(a1) + int'(a2)) % dep[i];
          w1   = '0;
          if (int'(a1) < dep[i])
            w1 = (wok && byp[i] && wa == a1) ? (wd & msk) : mm[i][a1];
          hd1[i] = w1;
          hd2[i] = (wok && byp[i] && int'(wa) == idx2) ? (wd & msk) : mm[i][idx2];
          hb[i]  = (int'(bs) < dwid[i]) ? w1[bs] : 1'b0;
        end
        if (wok) mm[i][wa] = wd & msk;
      end
      e.busy = bm[i];
      e.d1   = hd1[i];
      e.d2   = hd2[i];
      e.bt   = hb[i];
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    @(posedge clk);
    #1;
    e = qa.pop_front();
    check("a.rd_valid",   {7'b0, a_rv},   {7'b0, e.rv});
    check("a.err_oob",    {7'b0, a_err},  {7'b0, e.err});
    check("a.busy",       {7'b0, a_busy}, {7'b0, e.busy});
    check("a.data_out1",  a_d1,           e.d1);
    check("a.data_out2",  a_d2,           e.d2);
    check("a.single_bit", {7'b0, a_bit},  {7'b0, e.bt});
    e = qb.pop_front();
    check("b.rd_valid",   {7'b0, b_rv},   {7'b0, e.rv});
    check("b.err_oob",    {7'b0, b_err},  {7'b0, e.err});
    check("b.busy",       {7'b0, b_busy}, {7'b0, e.busy});
    check("b.data_out1",  {2'b0, b_d1},   e.d1);
    check("b.data_out2",  {2'b0, b_d2},   e.d2);
    check("b.single_bit", {7'b0, b_bit},  {7'b0, e.bt});
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0; bit_sel = '0;

    // Reset state, then clear in progress with ignored writes and reads
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 3'd0);
    for (int k = 0; k < 100; k++)
      step(0, 1, 8'(k), 8'hFF, 1, 8'(k), 8'h00, 3'd0);
    // Reset at clr_ptr=100 with a write and read pending: clear restarts
    step(1, 1, 8'h05, 8'h77, 1, 8'h05, 8'h00, 3'd0);
    for (int k = 0; k < 260; k++)
      step(0, (k < 256), 8'($urandom_range(255)), 8'($urandom_range(255)) | 8'h01,
           0, 8'h00, 8'h00, 3'd0);

    // Sweep every base address with random offsets and bit selects
    for (int k = 0; k < 256; k++)
      step(0, 0, 8'h00, 8'h00, 1, 8'(k), 8'($urandom_range(255)), 3'($urandom_range(7)));

    // Base/offset lookup with a bit select
    step(0, 1, 8'h03, 8'hA5, 0, 8'h00, 8'h00, 3'd0);
    step(0, 1, 8'h07, 8'h3C, 0, 8'h00, 8'h00, 3'd0);
    step(0, 0, 8'h00, 8'h00, 1, 8'h03, 8'h04, 3'd2);
    step(0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h20, 3'd0);
    // Wrap-around offset, then a base beyond the smaller depth
    step(0, 1, 8'h04, 8'h5A, 0, 8'h00, 8'h00, 3'd0);
    step(0, 0, 8'h00, 8'h00, 1, 8'hC6, 8'h06, 3'd1);
    step(0, 0, 8'h00, 8'h00, 1, 8'hC8, 8'h3C, 3'd3);
    step(0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 3'd7);
    // Same-cycle write/read on base and on offset index
    step(0, 1, 8'h22, 8'h11, 0, 8'h00, 8'h00, 3'd0);
    step(0, 1, 8'h22, 8'hF0, 1, 8'h22, 8'h00, 3'd4);
    step(0, 0, 8'h00, 8'h00, 1, 8'h22, 8'h00, 3'd4);
    step(0, 1, 8'h30, 8'h9B, 1, 8'h10, 8'h20, 3'd0);
    step(0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h20, 3'd0);
    // Out-of-range write, then read of the aliased address
    step(0, 1, 8'hC8, 8'h66, 0, 8'h00, 8'h00, 3'd0);
    step(0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 3'd0);
    // Bit select past the narrow word, combined with a bad write
    step(0, 1, 8'hD0, 8'h01, 1, 8'h03, 8'h00, 3'd7);
    step(0, 0, 8'h00, 8'h00, 1, 8'h03, 8'h00, 3'd6);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 3'd0);

    // Random traffic
    for (int k = 0; k < 150; k++)
      step(0, 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)),
           1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)),
           3'($urandom_range(7)));

    // Reset arriving together with a read cancels its valid pulse
    step(0, 0, 8'h00, 8'h00, 1, 8'h03, 8'h00, 3'd0);
    step(1, 0, 8'h00, 8'h00, 1, 8'h03, 8'h00, 3'd0);
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
